// File: rtl/ef_dac_pkg.sv
// Shared types and constants for the DAC waveform generator.
package ef_dac_pkg;

    localparam int DAC_DW = 10;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        BURST,
        SETTLE,
        DONE
    } state_t;

endpackage

// File: rtl/ef_dac_wavegen_mem.sv
// Pattern memory: register array with one synchronous write port and one
// asynchronous read port. A write and a read of the same entry in one cycle
// returns the old contents.
module ef_dac_wavegen_mem
    import ef_dac_pkg::*;
#(
    parameter int MEM_AW = 6
) (
    input  logic              clk,
    input  logic              wr,
    input  logic [MEM_AW-1:0] waddr,
    input  logic [DAC_DW-1:0] wdata,
    input  logic [MEM_AW-1:0] raddr,
    output logic [DAC_DW-1:0] rdata
);

    logic [DAC_DW-1:0] mem [2**MEM_AW];

    // Host write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ef_dac_wavegen.sv
// DAC waveform generator: streams the pattern memory into the DAC FIFO in
// bursts of burst_len+1 samples, each burst gated by the FIFO low flag and
// followed by a settle gap so the FIFO level has time to update.
module ef_dac_wavegen
    import ef_dac_pkg::*;
#(
    parameter int MEM_AW     = 6,
    parameter int BL_W       = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_wr,
    input  logic [MEM_AW-1:0] mem_addr,
    input  logic [DAC_DW-1:0] mem_wdata,
    input  logic [MEM_AW-1:0] last_idx,
    input  logic              loop_en,
    input  logic [BL_W-1:0]   burst_len,
    input  logic              start,
    input  logic              stop,
    input  logic              dac_low,
    input  logic              dac_empty,
    output logic [DAC_DW-1:0] dac_data,
    output logic              dac_wr,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t            state_q, state_d;
    logic [MEM_AW-1:0] ptr_q, ptr_d;
    logic [BL_W-1:0]   bcnt_q, bcnt_d;
    logic [SC_W-1:0]   scnt_q, scnt_d;
    logic [DAC_DW-1:0] data_d;
    logic              wr_d;
    logic              done_d;
    logic              under_d;
    logic [DAC_DW-1:0] rd_data;

    ef_dac_wavegen_mem #(
        .MEM_AW(MEM_AW)
    ) u_mem (
        .clk  (clk),
        .wr   (mem_wr),
        .waddr(mem_addr),
        .wdata(mem_wdata),
        .raddr(ptr_q),
        .rdata(rd_data)
    );

    assign busy = (state_q != IDLE) && (state_q != DONE);

    // Next-state logic: playback sequencing, pointer/counter updates and the
    // next values of the registered FIFO write port and sticky flags.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        scnt_d  = scnt_q;
        wr_d    = 1'b0;
        data_d  = dac_data;
        done_d  = done;
        under_d = underrun;

        if ((state_q == BURST || state_q == SETTLE) && dac_empty) begin
            under_d = 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = WAIT;
                    ptr_d   = '0;
                    done_d  = 1'b0;
                    under_d = 1'b0;
                end
            end
            WAIT: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (dac_low) begin
                    state_d = BURST;
                    bcnt_d  = '0;
                end
            end
            BURST: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    wr_d   = 1'b1;
                    data_d = rd_data;
                    // End of a one-shot pattern wins over the end of a burst.
                    if (ptr_q == last_idx && !loop_en) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = (ptr_q == last_idx) ? '0 : ptr_q + 1'b1;
                        if (bcnt_q == burst_len) begin
                            state_d = SETTLE;
                            scnt_d  = '0;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end
            end
            SETTLE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (scnt_q == SC_W'(SETTLE_CYC - 1)) begin
                    state_d = WAIT;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            bcnt_q   <= '0;
            scnt_q   <= '0;
            dac_wr   <= 1'b0;
            dac_data <= '0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            bcnt_q   <= bcnt_d;
            scnt_q   <= scnt_d;
            dac_wr   <= wr_d;
            dac_data <= data_d;
            done     <= done_d;
            underrun <= under_d;
        end
    end

endmodule

// File: doc/ef_dac_wavegen.md
Name: ef_dac_wavegen

Overview:
Upstream sample source for the 10-bit DAC FIFO wrapper. Holds a host-loaded pattern memory and streams it into the DAC FIFO write port in bounded bursts, paced by the FIFO "low" indication. Supports one-shot and continuous-loop playback, and flags FIFO underruns during playback.

Parameters:
MEM_AW, 6, pattern memory address width; depth = 2**MEM_AW entries of 10 bits
BL_W, 4, width of burst_len
SETTLE_CYC, 2, idle cycles after each burst before dac_low is re-sampled; covers FIFO level/low update latency

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
mem_wr  in  1  pattern memory write strobe
mem_addr  in  MEM_AW  pattern memory write address
mem_wdata  in  10  pattern sample
last_idx  in  MEM_AW  index of last sample played; pattern length = last_idx+1
loop_en  in  1  1 = wrap to index 0 after last_idx; 0 = stop after last_idx
burst_len  in  BL_W  samples per burst minus 1 (0 -> 1 sample, 15 -> 16)
start  in  1  pulse: begin playback from index 0
stop  in  1  pulse: abort playback
dac_low  in  1  from DAC FIFO: level < threshold
dac_empty  in  1  from DAC FIFO: empty
dac_data  out  10  sample to DAC FIFO w_data (registered)
dac_wr  out  1  DAC FIFO write strobe (registered)
busy  out  1  state != IDLE and state != DONE
done  out  1  sticky; set on one-shot completion, cleared by start
underrun  out  1  sticky; dac_empty seen while in BURST or SETTLE with busy=1; cleared by start

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, ptr=0, burst ctr=0, dac_wr=0, dac_data=0, done=0, underrun=0. Memory contents not reset.
- Memory: synchronous write on mem_wr. Read is asynchronous from ptr. A same-cycle write to mem[ptr] is not visible: dac_data receives the old value.
- States: IDLE, WAIT, BURST, SETTLE, DONE.
- IDLE/DONE + start -> WAIT; ptr=0, done=0, underrun=0. start in any other state is ignored.
- WAIT: if dac_low=1 -> BURST, burst ctr=0.
- BURST, each cycle: dac_wr<=1, dac_data<=mem[ptr].
  - ptr==last_idx and loop_en=0 -> DONE, done<=1 next cycle.
  - ptr==last_idx and loop_en=1 -> ptr<=0 and playback continues.
  - otherwise ptr<=ptr+1.
  - burst ctr==burst_len -> SETTLE, settle ctr=0; else burst ctr++.
  - Completion takes priority over burst end.
- SETTLE: dac_wr=0 for SETTLE_CYC cycles, then -> WAIT.
- Latency: dac_low high in WAIT -> first dac_wr exactly 2 cycles later (WAIT->BURST edge, then registered output).
- Burst writes are back-to-back: exactly burst_len+1 consecutive cycles of dac_wr=1, unless completion or stop ends the burst early.
- Headroom: dac_wr ignores FIFO full. Software guarantees threshold + burst_len + 1 <= FIFO depth.
- stop (any busy state): -> IDLE next edge; dac_wr=0 from the following cycle; ptr held; done not set. stop takes priority over start and completion in the same cycle.
- last_idx and loop_en are sampled live; changing them mid-playback is legal. If ptr > last_idx at the time of a change, ptr increments and wraps at 2**MEM_AW before hitting last_idx.
- dac_wr is never high in IDLE, WAIT, SETTLE or DONE (one cycle after entry).
- Arithmetic: ptr is MEM_AW bits and wraps modulo 2**MEM_AW. Counters do not saturate.

Decomposition:
- Shared package ef_dac_pkg: state enum (IDLE, WAIT, BURST, SETTLE, DONE) and DAC_DW=10.
- One sub-module, ef_dac_wavegen_mem: 2**MEM_AW x 10 register array, 1 sync write port, 1 async read port.
- FSM, pointer and counters stay in the top module.

Test Plan:
- One-shot: mem[0..7]=0x000,0x080,...,0x380; last_idx=7; burst_len=3; loop_en=0; dac_low=1 held; start -> 4 writes 0x000..0x180, 2 idle cycles, 1 idle (WAIT), 4 writes 0x200..0x380, then done=1, busy=0, no further dac_wr.
- Loop: last_idx=2, loop_en=1, burst_len=7, dac_low=1 -> 8 consecutive writes with data indices 0,1,2,0,1,2,0,1; done stays 0.
- Pacing: dac_low=0 after start -> no dac_wr for 50 cycles. Raise dac_low -> first dac_wr exactly 2 cycles later.
- Stop mid-burst: burst_len=15, assert stop on 5th write cycle -> exactly 5 writes total; busy=0 next cycle; done=0.
- Underrun/reset: dac_empty=1 during SETTLE -> underrun=1, held until the next start. Assert rst mid-BURST -> next cycle dac_wr=0, dac_data=0, state IDLE, flags 0.
- Memory collision: mem_wr to mem[ptr] with 0x3FF in the cycle it is read -> dac_data shows the old value; a replay shows 0x3FF.
